dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
Two-port arbiter that shares the single-ported, synchronous-read data memory between port 0 (core load/store unit) and port 1 (DMA/debug loader). It grants at most one request per cycle using round-robin, with an optional bounded lock for atomic read-modify-write sequences. It range-checks and alignment-checks every granted access. It routes the one-cycle-late read data back to the port that issued the read.

Parameters:
MEM_BYTES, 2048, size of the data RAM in bytes; a granted address >= MEM_BYTES is out of range
LOCK_MAX, 4, maximum consecutive locked grants to one port while the other port is waiting (must be >= 1)

Ports:
clk  in  1  system clock, rising-edge
rst  in  1  asynchronous, active-high reset
p0_req  in  1  port 0 request, held until granted
p0_we  in  1  port 0 write enable (0 = read)
p0_lock  in  1  port 0 requests that ownership be kept on the next cycle
p0_addr  in  32  port 0 byte address
p0_wdata  in  32  port 0 write data
p0_gnt  out  1  port 0 request accepted this cycle
p0_rvalid  out  1  port 0 read data valid
p0_rdata  out  32  port 0 read data
p0_err  out  1  port 0 previously granted access faulted
p1_*  (same set and widths as p0_*)  port 1
mem_addr  out  32  to RAM address
mem_wdata  out  32  to RAM write data
mem_we  out  1  to RAM write enable
mem_rdata  in  32  from RAM, valid 1 cycle after the address is presented

Behaviour:
- Grant is combinational on the current cycle's inputs and registered state. The command is presented to the RAM in the same cycle. At most one gnt is high per cycle; gnt is never high without the matching req.
- State registers:
  - last (1b): port granted most recently. Resets to 1, so port 0 wins the first tie.
  - own_valid / own_port: which port held the grant in the previous cycle.
  - lock_cnt (clog2(LOCK_MAX)+1 bits).
  - rsp_valid / rsp_port / rsp_err: response pipeline for the previous grant.
- Grant decision, in priority order:
  - (a) Lock hold: own_valid, and the owner port has req=1 and lock=1, and not (the other port has req=1 and lock_cnt == LOCK_MAX-1) → grant the owner.
  - (b) Only one port has req=1 → grant that port.
  - (c) Both ports have req=1 → grant the port that is not last.
  - (d) Neither port has req=1 → no grant.
- Lock counter:
  - Increments on a case-(a) grant, saturating at LOCK_MAX-1.
  - Clears when ownership changes, when the owner drops lock, or when there is no grant.
  - A lock broken by the limit yields exactly one grant to the waiting port; the normal round-robin rules then apply.
- On any grant: last <= granted port; own_valid <= 1. With no grant, own_valid <= 0.
- Fault check:
  - fault = (addr >= MEM_BYTES) or (addr[1:0] != 0).
  - mem_we = granted we & ~fault. A faulting write never reaches the RAM.
- RAM command drive:
  - mem_addr / mem_wdata carry the granted port's values.
  - With no grant: mem_addr = 0, mem_wdata = 0, mem_we = 0.
- Response, cycle after a grant:
  - rsp_valid <= grant, rsp_port <= granted port, rsp_err <= fault; rsp_valid is registered only for reads.
  - pN_rvalid = rsp_valid & (rsp_port == N) & read.
  - pN_rdata = mem_rdata when pN_rvalid=1 and no fault; 0 otherwise.
  - pN_err pulses for one cycle on the cycle after a faulting grant, for reads and writes alike. rvalid still pulses for a faulting read, with rdata = 0.
- Back-to-back grants: a read granted in cycle t returns in t+1 while the grant in t+1 proceeds. Throughput is one access per cycle, latency is one cycle.
- Reset (async, any cycle):
  - All gnt, rvalid, err and mem_we go to 0 immediately; rdata = 0.
  - last = 1, own_valid = 0, lock_cnt = 0, rsp_valid = 0.
  - An in-flight read response is dropped.

Test Plan:
- Reset asserted mid-read (grant in cycle t, rst high in t+1) → p0_rvalid = 0, all gnt = 0 and mem_we = 0 during rst; after release, first tie goes to port 0.
- Both ports request reads continuously at addresses 0x10 and 0x20 → grants alternate p0, p1, p0, p1; each rvalid arrives 1 cycle after its gnt with RAM contents.
- p0 writes 0xDEADBEEF to 0x40, then p1 reads 0x40 the next cycle → p1_rdata = 0xDEADBEEF on the cycle after p1_gnt.
- p0 holds lock=1 with continuous req while p1 requests, LOCK_MAX=4 → p0 granted 4 consecutive cycles, then p1 granted once, then round-robin resumes.
- p1 write to 0x800, then p1 read from 0x802 → mem_we stays 0 and p1_err pulses after each grant; the read gives p1_rvalid=1 with p1_rdata=0.
- p0 only, no contention, reads 0x7FC → granted immediately, no err, rdata = RAM word 511.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter for a single-ported, synchronous-read data RAM.
// Supports a bounded lock for atomic sequences, checks range and alignment, and routes read data.
module dmem_arbiter #(
  parameter int unsigned MEM_BYTES = 2048,
  parameter int unsigned LOCK_MAX  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        p0_req,
  input  logic        p0_we,
  input  logic        p0_lock,
  input  logic [31:0] p0_addr,
  input  logic [31:0] p0_wdata,
  output logic        p0_gnt,
  output logic        p0_rvalid,
  output logic [31:0] p0_rdata,
  output logic        p0_err,
  input  logic        p1_req,
  input  logic        p1_we,
  input  logic        p1_lock,
  input  logic [31:0] p1_addr,
  input  logic [31:0] p1_wdata,
  output logic        p1_gnt,
  output logic        p1_rvalid,
  output logic [31:0] p1_rdata,
  output logic        p1_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned      CNT_W     = $clog2(LOCK_MAX) + 1;
  localparam logic [CNT_W-1:0] CNT_SAT   = CNT_W'(LOCK_MAX - 1);
  localparam logic [31:0]      MEM_LIMIT = 32'(MEM_BYTES);

  logic             last;
  logic             own_valid;
  logic             own_port;
  logic [CNT_W-1:0] lock_cnt;
  logic             rsp_valid;
  logic             rsp_port;
  logic             rsp_err;

  logic        owner_req;
  logic        owner_lock;
  logic        other_req;
  logic        hold;
  logic        gnt_any;
  logic        gnt_port;
  logic        sel_we;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic        fault;

  // Grant decision: lock hold first, then single requester, then round-robin tie-break.
  always_comb begin
    owner_req  = own_port ? p1_req  : p0_req;
    owner_lock = own_port ? p1_lock : p0_lock;
    other_req  = own_port ? p0_req  : p1_req;
    hold       = own_valid & owner_req & owner_lock & ~(other_req & (lock_cnt == CNT_SAT));
    gnt_any    = 1'b0;
    gnt_port   = 1'b0;
    if (rst) begin
      gnt_any = 1'b0;
    end else if (hold) begin
      gnt_any  = 1'b1;
      gnt_port = own_port;
    end else if (p0_req & p1_req) begin
      gnt_any  = 1'b1;
      gnt_port = ~last;
    end else if (p0_req | p1_req) begin
      gnt_any  = 1'b1;
      gnt_port = p1_req;
    end
  end

  // Mux the granted command onto the RAM; faulting writes are suppressed.
  always_comb begin
    sel_we    = gnt_port ? p1_we    : p0_we;
    sel_addr  = gnt_port ? p1_addr  : p0_addr;
    sel_wdata = gnt_port ? p1_wdata : p0_wdata;
    fault     = (sel_addr >= MEM_LIMIT) | (sel_addr[1:0] != 2'b00);
    mem_addr  = gnt_any ? sel_addr  : 32'h0;
    mem_wdata = gnt_any ? sel_wdata : 32'h0;
    mem_we    = gnt_any & sel_we & ~fault;
  end

  assign p0_gnt    = gnt_any & ~gnt_port;
  assign p1_gnt    = gnt_any & gnt_port;
  assign p0_rvalid = rsp_valid & ~rsp_port;
  assign p1_rvalid = rsp_valid & rsp_port;
  assign p0_err    = rsp_err & ~rsp_port;
  assign p1_err    = rsp_err & rsp_port;
  assign p0_rdata  = (p0_rvalid & ~rsp_err) ? mem_rdata : 32'h0;
  assign p1_rdata  = (p1_rvalid & ~rsp_err) ? mem_rdata : 32'h0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last      <= 1'b1;
      own_valid <= 1'b0;
      own_port  <= 1'b0;
      lock_cnt  <= '0;
      rsp_valid <= 1'b0;
      rsp_port  <= 1'b0;
      rsp_err   <= 1'b0;
    end else begin
      own_valid <= gnt_any;
      if (gnt_any) begin
        last     <= gnt_port;
        own_port <= gnt_port;
      end
      // Counter only survives consecutive lock-held grants to the same owner.
      if (gnt_any & hold)
        lock_cnt <= (lock_cnt == CNT_SAT) ? lock_cnt : lock_cnt + CNT_W'(1);
      else
        lock_cnt <= '0;
      rsp_valid <= gnt_any & ~sel_we;
      rsp_port  <= gnt_port;
      rsp_err   <= gnt_any & fault;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios then random traffic, checked every cycle
// against a transaction-level model with its own shadow copy of the RAM.
module tb_dmem_arbiter;

  localparam int unsigned MEM_BYTES = 2048;
  localparam int unsigned LOCK_MAX  = 4;
  localparam int unsigned WORDS     = MEM_BYTES / 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        p0_req, p0_we, p0_lock, p1_req, p1_we, p1_lock;
  logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
  logic        p0_gnt, p0_rvalid, p0_err, p1_gnt, p1_rvalid, p1_err;
  logic [31:0] p0_rdata, p1_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_we;

  dmem_arbiter #(.MEM_BYTES(MEM_BYTES), .LOCK_MAX(LOCK_MAX)) dut (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_we(p0_we), .p0_lock(p0_lock), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata), .p0_err(p0_err),
    .p1_req(p1_req), .p1_we(p1_we), .p1_lock(p1_lock), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata), .p1_err(p1_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int i);
    return (32'(i) * 32'h0001_0003) ^ 32'h5A00_00C3;
  endfunction

  // Synchronous-read RAM the arbiter drives; reloaded with a known pattern while in reset.
  logic [31:0] ram [WORDS];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(WORDS); i++) ram[i] <= init_word(i);
      mem_rdata <= 32'h0;
    end else begin
      if (mem_we) ram[mem_addr[10:2]] <= mem_wdata;
      mem_rdata <= ram[mem_addr[10:2]];
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  // Stimulus arrays, indexed by port.
  bit          req [2];
  bit          we  [2];
  bit          lock[2];
  logic [31:0] addr [2];
  logic [31:0] wdata[2];

  // Reference model state.
  int          m_last, m_owner, m_held, exp_g;
  bit          p_valid, p_read, p_fault;
  int          p_port;
  logic [31:0] p_data;
  logic [31:0] shadow [WORDS];

  // Observations from the most recent step.
  bit          obs_g0, obs_g1, obs_we, obs_rv0, obs_rv1, obs_err0, obs_err1;
  logic [31:0] obs_rd0, obs_rd1;

  task automatic model_reset();
    m_last = 1; m_owner = -1; m_held = 0; exp_g = -1;
    p_valid = 0; p_read = 0; p_fault = 0; p_port = 0; p_data = 32'h0;
    for (int i = 0; i < int'(WORDS); i++) shadow[i] = init_word(i);
  endtask

  task automatic drive();
    p0_req = req[0]; p0_we = we[0]; p0_lock = lock[0]; p0_addr = addr[0]; p0_wdata = wdata[0];
    p1_req = req[1]; p1_we = we[1]; p1_lock = lock[1]; p1_addr = addr[1]; p1_wdata = wdata[1];
  endtask

  task automatic idle_stim();
    for (int i = 0; i < 2; i++) begin
      req[i] = 0; we[i] = 0; lock[i] = 0; addr[i] = 32'h0; wdata[i] = 32'h0;
    end
  endtask

  task automatic set_port(input int p, input bit r, input bit w, input bit l,
                          input logic [31:0] a, input logic [31:0] d);
    req[p] = r; we[p] = w; lock[p] = l; addr[p] = a; wdata[p] = d;
  endtask

  // One clock of traffic: drive, check responses of the previous grant and this cycle's grant.
  task automatic step();
    int g;
    bit holding, f;
    logic [31:0] a;
    @(negedge clk);
    drive();
    #1;
    check("p0_rvalid", 32'(p0_rvalid), 32'(p_valid && p_read && p_port == 0));
    check("p1_rvalid", 32'(p1_rvalid), 32'(p_valid && p_read && p_port == 1));
    check("p0_err", 32'(p0_err), 32'(p_valid && p_fault && p_port == 0));
    check("p1_err", 32'(p1_err), 32'(p_valid && p_fault && p_port == 1));
    check("p0_rdata", p0_rdata, (p_valid && p_read && !p_fault && p_port == 0) ? p_data : 32'h0);
    check("p1_rdata", p1_rdata, (p_valid && p_read && !p_fault && p_port == 1) ? p_data : 32'h0);
    holding = (m_owner >= 0) && req[m_owner] && lock[m_owner]
              && !(req[1 - m_owner] && m_held >= int'(LOCK_MAX) - 1);
    if (holding)               g = m_owner;
    else if (req[0] && req[1]) g = 1 - m_last;
    else if (req[0])           g = 0;
    else if (req[1])           g = 1;
    else                       g = -1;
    a = (g >= 0) ? addr[g] : 32'h0;
    f = (g >= 0) && (a >= 32'(MEM_BYTES) || a[1:0] != 2'b00);
    check("p0_gnt", 32'(p0_gnt), 32'(g == 0));
    check("p1_gnt", 32'(p1_gnt), 32'(g == 1));
    check("mem_addr", mem_addr, a);
    check("mem_wdata", mem_wdata, (g >= 0) ? wdata[g] : 32'h0);
    check("mem_we", 32'(mem_we), 32'((g >= 0) && we[g] && !f));
    obs_g0 = p0_gnt; obs_g1 = p1_gnt; obs_we = mem_we;
    obs_rv0 = p0_rvalid; obs_rv1 = p1_rvalid; obs_err0 = p0_err; obs_err1 = p1_err;
    obs_rd0 = p0_rdata; obs_rd1 = p1_rdata;
    // Commit the expected effect of this cycle's grant.
    m_held  = holding ? m_held + 1 : 0;
    m_owner = g;
    exp_g   = g;
    p_valid = (g >= 0);
    p_fault = f;
    p_port  = (g >= 0) ? g : 0;
    p_read  = (g >= 0) && !we[g];
    p_data  = 32'h0;
    if (g >= 0) begin
      m_last = g;
      if (!f && we[g]) shadow[a[10:2]] = wdata[g];
      if (!f && !we[g]) p_data = shadow[a[10:2]];
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_p0_gnt"}, 32'(p0_gnt), 32'h0);
    check({tag, "_p1_gnt"}, 32'(p1_gnt), 32'h0);
    check({tag, "_mem_we"}, 32'(mem_we), 32'h0);
    check({tag, "_p0_rvalid"}, 32'(p0_rvalid), 32'h0);
    check({tag, "_p1_rvalid"}, 32'(p1_rvalid), 32'h0);
    check({tag, "_p0_err"}, 32'(p0_err), 32'h0);
    check({tag, "_p0_rdata"}, p0_rdata, 32'h0);
  endtask

  int exp_lock_seq [7] = '{0, 0, 0, 0, 1, 0, 1};

  initial begin
    idle_stim();
    drive();
    rst = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    #1 check_reset_outputs("por");
    @(negedge clk);
    rst = 1'b0;

    // Continuous contention: strict alternation starting at port 0.
    set_port(0, 1, 0, 0, 32'h10, 32'h0);
    set_port(1, 1, 0, 0, 32'h20, 32'h0);
    for (int k = 0; k < 8; k++) begin
      step();
      check("rr_p0_gnt", 32'(obs_g0), 32'(k % 2 == 0));
      if (k > 0)
        check("rr_rdata", (k % 2 == 1) ? obs_rd0 : obs_rd1, (k % 2 == 1) ? init_word(4) : init_word(8));
    end

    // Write followed immediately by a read of the same word from the other port.
    idle_stim();
    set_port(0, 1, 1, 0, 32'h40, 32'hDEADBEEF);
    step();
    idle_stim();
    set_port(1, 1, 0, 0, 32'h40, 32'h0);
    step();
    idle_stim();
    step();
    check("wr_rd_rvalid", 32'(obs_rv1), 32'h1);
    check("wr_rd_rdata", obs_rd1, 32'hDEADBEEF);

    // Lock limit: port 0 keeps LOCK_MAX grants, port 1 then gets exactly one.
    set_port(1, 1, 0, 0, 32'h44, 32'h0);
    step();
    idle_stim();
    step();
    for (int k = 0; k < 7; k++) begin
      set_port(0, 1, 0, k < 5, 32'h100, 32'h0);
      set_port(1, 1, 0, 0, 32'h104, 32'h0);
      step();
      check("lock_p1_gnt", 32'(obs_g1), 32'(exp_lock_seq[k]));
    end

    // Out-of-range write and misaligned read both fault.
    idle_stim();
    set_port(1, 1, 1, 0, 32'h800, 32'h1234_5678);
    step();
    check("oor_wr_we", 32'(obs_we), 32'h0);
    set_port(1, 1, 0, 0, 32'h802, 32'h0);
    step();
    check("oor_wr_err", 32'(obs_err1), 32'h1);
    check("mis_rd_we", 32'(obs_we), 32'h0);
    idle_stim();
    step();
    check("mis_rd_err", 32'(obs_err1), 32'h1);
    check("mis_rd_rvalid", 32'(obs_rv1), 32'h1);
    check("mis_rd_rdata", obs_rd1, 32'h0);

    // Last word of the RAM, uncontended.
    set_port(0, 1, 0, 0, 32'h7FC, 32'h0);
    step();
    check("top_gnt", 32'(obs_g0), 32'h1);
    idle_stim();
    step();
    check("top_err", 32'(obs_err0), 32'h0);
    check("top_rdata", obs_rd0, init_word(511));

    // Reset lands on the cycle a read response is due.
    set_port(0, 1, 0, 0, 32'h10, 32'h0);
    step();
    @(negedge clk);
    rst = 1'b1;
    set_port(1, 1, 1, 0, 32'h30, 32'hCAFE_F00D);
    drive();
    #1 check_reset_outputs("mid");
    @(negedge clk);
    #1 check_reset_outputs("mid2");
    @(negedge clk);
    rst = 1'b0;
    idle_stim();
    drive();
    model_reset();
    set_port(0, 1, 0, 0, 32'h10, 32'h0);
    set_port(1, 1, 0, 0, 32'h20, 32'h0);
    step();
    check("post_rst_tie", 32'(obs_g0), 32'h1);

    // Random traffic; a request is held with its command until granted.
    idle_stim();
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (!req[i] && ($urandom % 10) < 6) begin
          int sel;
          req[i] = 1;
          we[i]  = $urandom % 2;
          wdata[i] = $urandom;
          sel = $urandom % 10;
          if (sel < 7)       addr[i] = 32'($urandom_range(0, 31)) * 4;
          else if (sel == 7) addr[i] = 32'($urandom_range(0, WORDS - 1)) * 4 + 32'($urandom_range(1, 3));
          else if (sel == 8) addr[i] = 32'(MEM_BYTES) + 32'($urandom_range(0, 63)) * 4;
          else               addr[i] = 32'($urandom_range(0, WORDS - 1)) * 4;
        end
        lock[i] = ($urandom % 4) != 0;
      end
      step();
      if (exp_g >= 0) req[exp_g] = 0;
    end

    idle_stim();
    step();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
